// File: rtl/zero_io_pkg.sv
// Shared definitions for the Zero program I/O host.
//   state_t   : host run state (IDLE -> RUN -> DONE)
//   SEL_IN    : cfg_sel value addressing the input table
//   SEL_EXP   : cfg_sel value addressing the expected-output table
//   FAIL_NONE : all-ones pattern reported by fail_index when nothing failed
//               (slice the low WIDTH bits at the point of use)
package zero_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SEL_IN  = 1'b0;
  localparam logic SEL_EXP = 1'b1;

  localparam logic [63:0] FAIL_NONE = '1;

endpackage

// File: rtl/zero_io_table.sv
// Single-write-port, asynchronous-read word table.
// Writes whose address falls outside DEPTH are dropped; reads outside DEPTH
// return zero, so callers may present a pointer that has run off the end.
// Ports:
//   clock  in   rising-edge clock
//   we     in   write strobe
//   waddr  in   [WAW] write index
//   wdata  in   [WIDTH] write word
//   raddr  in   [RAW] read index
//   rdata  out  [WIDTH] word at raddr (combinational)
module zero_io_table #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 3,
  parameter int WAW   = 2,
  parameter int RAW   = 2
) (
  input  logic             clock,
  input  logic             we,
  input  logic [WAW-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RAW-1:0]   raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the table has no reset on purpose; contents must survive a reset so
  // a test can be rerun without reloading, and it keeps this a plain RAM.
  always_ff @(posedge clock) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem[IW'(waddr)] <= wdata;
    end
  end

  assign rdata = (32'(raddr) < DEPTH) ? mem[IW'(raddr)] : '0;

endmodule

// File: rtl/zero_io_host.sv
// Testbench-side host for the Zero program I/O channels.
// Streams a preloaded input table into the program's input channel, reports
// the remaining input count (in_size), checks every word on the program's
// output channel against a preloaded expected table, and raises
// finished/success when the run ends (all outputs seen, or idle timeout).
//
// Optional build macro ZERO_IO_HOST_OVERRUN_EN: when defined, any word the
// program emits after the run is complete clears success and reports
// fail_index = NOUT. When undefined such words are silently discarded.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   cfg_we      in   table write strobe (honoured in IDLE only)
//   cfg_sel     in   SEL_IN = input table, SEL_EXP = expected table
//   cfg_addr    in   table index
//   cfg_data    in   table word
//   start       in   one-cycle pulse, IDLE -> RUN
//   in_valid    out  input word available
//   in_data     out  current input word
//   in_ready    in   program consumes the word
//   in_size     out  input words not yet consumed
//   out_valid   in   program emits a word
//   out_data    in   emitted word
//   out_ready   out  host accepts words
//   finished    out  run complete (sticky until reset)
//   success     out  all outputs matched (meaningful when finished)
//   fail_index  out  index of first mismatch, all ones if none
module zero_io_host
  import zero_io_pkg::*;
#(
  parameter int  WIDTH   = 12,
  parameter int  NIN     = 3,
  parameter int  NOUT    = 9,
  parameter int  TIMEOUT = 64,
  localparam int CAW     = $clog2((NIN > NOUT) ? NIN : NOUT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [CAW-1:0]   cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             start,
  output logic             in_valid,
  output logic [WIDTH-1:0] in_data,
  input  logic             in_ready,
  output logic [WIDTH-1:0] in_size,
  input  logic             out_valid,
  input  logic [WIDTH-1:0] out_data,
  output logic             out_ready,
  output logic             finished,
  output logic             success,
  output logic [WIDTH-1:0] fail_index
);

  localparam int IPW = $clog2(NIN + 1);
  localparam int OPW = $clog2(NOUT + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [IPW-1:0]   in_ptr, in_ptr_nxt;
  logic [OPW-1:0]   out_ptr, out_ptr_nxt;
  logic [TW-1:0]    idle_cnt, idle_cnt_nxt;
  logic             match, match_nxt;
  logic             finished_nxt, success_nxt;
  logic [WIDTH-1:0] fail_index_nxt;

  logic             in_we, exp_we;
  logic [WIDTH-1:0] exp_word;
  logic             in_xfer, out_xfer, word_bad;

  // Tables are only writable while idle so a run sees a stable image.
  assign in_we  = cfg_we && (state == IDLE) && (cfg_sel == SEL_IN);
  assign exp_we = cfg_we && (state == IDLE) && (cfg_sel == SEL_EXP);

  zero_io_table #(
    .WIDTH (WIDTH),
    .DEPTH (NIN),
    .WAW   (CAW),
    .RAW   (IPW)
  ) u_in_tab (
    .clock (clock),
    .we    (in_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (in_ptr),
    .rdata (in_data)
  );

  zero_io_table #(
    .WIDTH (WIDTH),
    .DEPTH (NOUT),
    .WAW   (CAW),
    .RAW   (OPW)
  ) u_exp_tab (
    .clock (clock),
    .we    (exp_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (out_ptr),
    .rdata (exp_word)
  );

  assign in_size = WIDTH'(IPW'(NIN) - in_ptr);

  // NOTE: every register uses <= so all state advances together on the edge;
  // the next-state values are computed separately in the combinational block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      in_ptr     <= '0;
      out_ptr    <= '0;
      idle_cnt   <= '0;
      match      <= 1'b1;
      finished   <= 1'b0;
      success    <= 1'b0;
      fail_index <= FAIL_NONE[WIDTH-1:0];
    end else begin
      state      <= state_nxt;
      in_ptr     <= in_ptr_nxt;
      out_ptr    <= out_ptr_nxt;
      idle_cnt   <= idle_cnt_nxt;
      match      <= match_nxt;
      finished   <= finished_nxt;
      success    <= success_nxt;
      fail_index <= fail_index_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    in_ptr_nxt     = in_ptr;
    out_ptr_nxt    = out_ptr;
    idle_cnt_nxt   = idle_cnt;
    match_nxt      = match;
    finished_nxt   = finished;
    success_nxt    = success;
    fail_index_nxt = fail_index;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    in_xfer        = 1'b0;
    out_xfer       = 1'b0;
    word_bad       = (out_data != exp_word);

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        in_valid  = (in_ptr < IPW'(NIN));
        out_ready = 1'b1;
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid;

        if (in_xfer) begin
          in_ptr_nxt = in_ptr + 1'b1;
        end

        if (out_xfer) begin
          // Only the first mismatch is recorded.
          if (word_bad && match) begin
            match_nxt      = 1'b0;
            fail_index_nxt = WIDTH'(out_ptr);
          end
          out_ptr_nxt = out_ptr + 1'b1;
          if (out_ptr == OPW'(NOUT - 1)) begin
            state_nxt    = DONE;
            finished_nxt = 1'b1;
            success_nxt  = match && !word_bad;
          end
        end

        if (in_xfer || out_xfer) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
          // This idle cycle is the TIMEOUT-th in a row: abort the run.
          idle_cnt_nxt   = TW'(TIMEOUT);
          state_nxt      = DONE;
          finished_nxt   = 1'b1;
          success_nxt    = 1'b0;
          fail_index_nxt = WIDTH'(out_ptr);
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end

      DONE: begin
        // Keep accepting so a chatty program never stalls after the run.
        out_ready = 1'b1;
`ifdef ZERO_IO_HOST_OVERRUN_EN
        if (out_valid) begin
          success_nxt    = 1'b0;
          fail_index_nxt = WIDTH'(NOUT);
        end
`endif
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_zero_io_host.sv
// Self-checking bench for zero_io_host. A transaction-level model (counts of
// consumed/produced words, first-bad index, idle-cycle count) predicts every
// output, and one monitor process compares the DUT against it each cycle.
// Directed program-like sequences add hand-computed literal expectations.
module tb_zero_io_host;

  localparam int WIDTH   = 12;
  localparam int NIN     = 3;
  localparam int NOUT    = 9;
  localparam int TIMEOUT = 64;
  localparam int CAW     = 4;
  localparam int NONE    = 4095;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cfg_we = 1'b0;
  logic             cfg_sel = 1'b0;
  logic [CAW-1:0]   cfg_addr = '0;
  logic [WIDTH-1:0] cfg_data = '0;
  logic             start = 1'b0;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready = 1'b0;
  logic [WIDTH-1:0] in_size;
  logic             out_valid = 1'b0;
  logic [WIDTH-1:0] out_data = '0;
  logic             out_ready;
  logic             finished;
  logic             success;
  logic [WIDTH-1:0] fail_index;

  zero_io_host #(
    .WIDTH   (WIDTH),
    .NIN     (NIN),
    .NOUT    (NOUT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .in_size    (in_size),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .finished   (finished),
    .success    (success),
    .fail_index (fail_index)
  );

  always #5 clock = ~clock;

  int in_vec  [NIN]  = '{33, 22, 11};
  int exp_vec [NOUT] = '{1, 2, 3, 3, 33, 2, 22, 1, 11};

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int m_state    = 0;   // 0 idle, 1 running, 2 done
  int m_consumed = 0;
  int m_produced = 0;
  int m_first_bad = -1;
  int m_idle     = 0;
  bit m_fin      = 1'b0;
  bit m_succ     = 1'b0;
  int m_fail     = NONE;
  int m_in_tab  [NIN];
  int m_exp_tab [NOUT];

  task automatic model_step();
    bit xin, xout;
    if (reset) begin
      m_state = 0; m_consumed = 0; m_produced = 0; m_first_bad = -1;
      m_idle = 0; m_fin = 0; m_succ = 0; m_fail = NONE;
      return;
    end
    if (m_state == 0) begin
      if (cfg_we) begin
        if (!cfg_sel && int'(cfg_addr) < NIN) m_in_tab[cfg_addr] = int'(cfg_data);
        if (cfg_sel && int'(cfg_addr) < NOUT) m_exp_tab[cfg_addr] = int'(cfg_data);
      end
      if (start) m_state = 1;
    end else if (m_state == 1) begin
      xin  = (m_consumed < NIN) && in_ready;
      xout = out_valid;
      if (xin) m_consumed++;
      if (xout) begin
        if (int'(out_data) != m_exp_tab[m_produced] && m_first_bad < 0) begin
          m_first_bad = m_produced;
          m_fail = m_produced;
        end
        m_produced++;
        if (m_produced == NOUT) begin
          m_state = 2; m_fin = 1; m_succ = (m_first_bad < 0);
        end
      end
      if (xin || xout) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_state = 2; m_fin = 1; m_succ = 0; m_fail = m_produced;
        end
      end
    end else begin
`ifdef ZERO_IO_HOST_OVERRUN_EN
      if (out_valid) begin
        m_succ = 0; m_fail = NOUT;
      end
`endif
    end
  endtask

  task automatic compare_outputs();
    bit m_in_valid;
    m_in_valid = (m_state == 1) && (m_consumed < NIN);
    check("m_in_valid",   in_valid,   m_in_valid);
    check("m_in_size",    in_size,    NIN - m_consumed);
    check("m_out_ready",  out_ready,  m_state != 0);
    check("m_finished",   finished,   m_fin);
    check("m_success",    success,    m_succ);
    check("m_fail_index", fail_index, m_fail);
    if (m_in_valid) check("m_in_data", in_data, m_in_tab[m_consumed]);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      if (chk_en) model_step();
      @(negedge clock);
      if (chk_en) compare_outputs();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic load_tables();
    for (int i = 0; i < NIN; i++) begin
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = CAW'(i); cfg_data = WIDTH'(in_vec[i]);
      cyc();
    end
    for (int i = 0; i < NOUT; i++) begin
      cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = CAW'(i); cfg_data = WIDTH'(exp_vec[i]);
      cyc();
    end
    // Out-of-range writes must be dropped.
    cfg_sel = 1'b0; cfg_addr = 4'd3;  cfg_data = 12'd777; cyc();
    cfg_sel = 1'b1; cfg_addr = 4'd12; cfg_data = 12'd5;   cyc();
    cfg_we = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic out_word(input int w);
    out_valid = 1'b1;
    out_data  = WIDTH'(w);
    cyc();
    out_valid = 1'b0;
  endtask

  task automatic in_word();
    in_ready = 1'b1;
    cyc();
    in_ready = 1'b0;
  endtask

  // Program: out 1,2,3; then 3x { s=inSize; w=in; out s; out w }.
  task automatic run_program(input int bad_pos, input int bad_val);
    int p;
    int seq [NOUT];
    p = 0;
    seq[0] = 1; seq[1] = 2; seq[2] = 3;
    for (int i = 0; i < NIN; i++) begin
      seq[3 + 2*i] = 3 - i;
      seq[4 + 2*i] = in_vec[i];
    end
    for (int k = 0; k < 3; k++) begin
      out_word((p == bad_pos) ? bad_val : seq[p]);
      p++;
    end
    for (int i = 0; i < NIN; i++) begin
      check("in_size_read", in_size, 3 - i);
      check("in_word_read", in_data, in_vec[i]);
      in_word();
      out_word((p == bad_pos) ? bad_val : seq[p]);
      p++;
      if (p == NOUT - 1) check("not_finished_early", finished, 0);
      out_word((p == bad_pos) ? bad_val : seq[p]);
      p++;
    end
    check("in_size_end", in_size, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_finished",   finished,   0);
    check("rst_success",    success,    0);
    check("rst_in_valid",   in_valid,   0);
    check("rst_out_ready",  out_ready,  0);
    check("rst_in_size",    in_size,    3);
    check("rst_fail_index", fail_index, NONE);

    // Passing run, then a word after completion and an ignored start.
    load_tables();
    start_run();
    run_program(-1, 0);
    check("t1_finished",   finished,   1);
    check("t1_success",    success,    1);
    check("t1_fail_index", fail_index, NONE);
    out_word(99);
`ifdef ZERO_IO_HOST_OVERRUN_EN
    check("t1_overrun_success", success,    0);
    check("t1_overrun_index",   fail_index, 9);
`else
    check("t1_overrun_success", success,    1);
    check("t1_overrun_index",   fail_index, NONE);
`endif
    start_run();
    check("t1_done_sticky", finished, 1);
    check("t1_done_in_valid", in_valid, 0);

    // Fifth output wrong.
    do_reset();
    load_tables();
    start_run();
    run_program(4, 34);
    check("t2_finished",   finished,   1);
    check("t2_success",    success,    0);
    check("t2_fail_index", fail_index, 4);

    // Idle timeout.
    do_reset();
    start_run();
    repeat (TIMEOUT - 1) cyc();
    check("t3_not_yet", finished, 0);
    cyc();
    check("t3_finished",   finished,   1);
    check("t3_success",    success,    0);
    check("t3_fail_index", fail_index, 0);

    // Simultaneous in/out transfers; a cfg write during RUN is ignored.
    do_reset();
    load_tables();
    start_run();
    for (int i = 0; i < 3; i++) begin
      cfg_we = (i == 0); cfg_sel = 1'b0; cfg_addr = 4'd2; cfg_data = 12'd555;
      in_ready = 1'b1; out_valid = 1'b1; out_data = WIDTH'(exp_vec[i]);
      cyc();
    end
    cfg_we = 1'b0; in_ready = 1'b0; out_valid = 1'b0;
    check("t4_in_valid", in_valid, 0);
    check("t4_in_size",  in_size,  0);
    for (int i = 3; i < NOUT; i++) out_word(exp_vec[i]);
    check("t4_finished", finished, 1);
    check("t4_success",  success,  1);

    // Reset mid-run, then a full rerun.
    do_reset();
    load_tables();
    start_run();
    for (int i = 0; i < 4; i++) out_word(exp_vec[i]);
    do_reset();
    check("t5_rst_finished", finished, 0);
    check("t5_rst_in_size",  in_size,  3);
    check("t5_rst_in_valid", in_valid, 0);
    load_tables();
    start_run();
    run_program(-1, 0);
    check("t5_finished",   finished,   1);
    check("t5_success",    success,    1);
    check("t5_fail_index", fail_index, NONE);

    cyc();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
